// File: rtl/reg_file_2r1w.sv
// Register file with one write port and two independent registered read ports.
// Supports an optional write-to-read bypass and an optional hard-wired zero entry.
module reg_file_2r1w #(
    parameter int WIDTH    = 4,
    parameter int ADDR_W   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;

    // Writes to entry 0 are dropped when it is the hard-wired zero register.
    assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

    // Value a read of raddr captures at this edge, resolving a same-edge write.
    function automatic logic [WIDTH-1:0] read_value(input logic [ADDR_W-1:0] raddr);
        logic [WIDTH-1:0] val;
        val = mem[raddr];
        if ((ZERO_REG != 0) && (raddr == '0))
            val = '0;
        else if ((BYPASS != 0) && we && (raddr == waddr))
            val = wdata;
        return val;
    endfunction

    always_comb begin
        rd_next_a = read_value(raddr_a);
        rd_next_b = read_value(raddr_b);
    end

    // NOTE: every entry is cleared by the asynchronous reset, so the array is built
    // from flops rather than a RAM macro; that is what lets reset wipe contents instantly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            // NOTE: non-blocking, so same-edge reads above still see the old contents.
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a  <= '0;
            rvalid_a <= 1'b0;
            rdata_b  <= '0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= re_a;
            rvalid_b <= re_b;
            if (re_a)
                rdata_a <= rd_next_a;
            if (re_b)
                rdata_b <= rd_next_b;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench: four builds of reg_file_2r1w share one stimulus stream and
// are compared against a per-build array model of the register file rules.
module tb_reg_file_2r1w;

    localparam int NB = 4;
    // Builds: 0 default, 1 no bypass, 2 zero register, 3 WIDTH=8/ADDR_W=3.
    localparam int CFG_W   [NB] = '{4, 4, 4, 8};
    localparam int CFG_AW  [NB] = '{2, 2, 2, 3};
    localparam int CFG_BYP [NB] = '{1, 0, 1, 1};
    localparam int CFG_ZR  [NB] = '{0, 0, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic       re_a = 1'b0;
    logic [2:0] raddr_a = '0;
    logic       re_b = 1'b0;
    logic [2:0] raddr_b = '0;

    logic [3:0] rda0, rdb0, rda1, rdb1, rda2, rdb2;
    logic [7:0] rda3, rdb3;
    logic       rva [NB];
    logic       rvb [NB];
    logic [7:0] obs_rda [NB];
    logic [7:0] obs_rdb [NB];

    logic [7:0] mdl_mem [NB][8];
    logic [7:0] exp_rda [NB];
    logic [7:0] exp_rdb [NB];
    logic       exp_rva [NB];
    logic       exp_rvb [NB];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_file_2r1w #(.WIDTH(4), .ADDR_W(2), .BYPASS(1), .ZERO_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[1:0]), .wdata(wdata[3:0]),
        .re_a(re_a), .raddr_a(raddr_a[1:0]), .rdata_a(rda0), .rvalid_a(rva[0]),
        .re_b(re_b), .raddr_b(raddr_b[1:0]), .rdata_b(rdb0), .rvalid_b(rvb[0]));
    reg_file_2r1w #(.WIDTH(4), .ADDR_W(2), .BYPASS(0), .ZERO_REG(0)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[1:0]), .wdata(wdata[3:0]),
        .re_a(re_a), .raddr_a(raddr_a[1:0]), .rdata_a(rda1), .rvalid_a(rva[1]),
        .re_b(re_b), .raddr_b(raddr_b[1:0]), .rdata_b(rdb1), .rvalid_b(rvb[1]));
    reg_file_2r1w #(.WIDTH(4), .ADDR_W(2), .BYPASS(1), .ZERO_REG(1)) u2 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[1:0]), .wdata(wdata[3:0]),
        .re_a(re_a), .raddr_a(raddr_a[1:0]), .rdata_a(rda2), .rvalid_a(rva[2]),
        .re_b(re_b), .raddr_b(raddr_b[1:0]), .rdata_b(rdb2), .rvalid_b(rvb[2]));
    reg_file_2r1w #(.WIDTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) u3 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda3), .rvalid_a(rva[3]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb3), .rvalid_b(rvb[3]));

    always_comb begin
        obs_rda[0] = {4'h0, rda0};
        obs_rdb[0] = {4'h0, rdb0};
        obs_rda[1] = {4'h0, rda1};
        obs_rdb[1] = {4'h0, rdb1};
        obs_rda[2] = {4'h0, rda2};
        obs_rdb[2] = {4'h0, rdb2};
        obs_rda[3] = rda3;
        obs_rdb[3] = rdb3;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < 8; i++)
                mdl_mem[k][i] = '0;
            exp_rda[k] = '0;
            exp_rdb[k] = '0;
            exp_rva[k] = 1'b0;
            exp_rvb[k] = 1'b0;
        end
    endtask

    // Value build k returns for a read of address ra given the current write inputs.
    function automatic logic [7:0] model_read(input int k, input int ra, input int wa, input logic [7:0] wd);
        if (CFG_ZR[k] != 0 && ra == 0)
            return 8'h00;
        if (we && ra == wa && CFG_BYP[k] != 0)
            return wd;
        return mdl_mem[k][ra];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < NB; k++) begin
            int amask, wa, ra, rb;
            logic [7:0] dmask, wd;
            amask = (1 << CFG_AW[k]) - 1;
            dmask = 8'((1 << CFG_W[k]) - 1);
            wa = int'(waddr) & amask;
            ra = int'(raddr_a) & amask;
            rb = int'(raddr_b) & amask;
            wd = wdata & dmask;
            if (re_a) exp_rda[k] = model_read(k, ra, wa, wd);
            if (re_b) exp_rdb[k] = model_read(k, rb, wa, wd);
            exp_rva[k] = re_a;
            exp_rvb[k] = re_b;
            if (we && !(CFG_ZR[k] != 0 && wa == 0))
                mdl_mem[k][wa] = wd;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NB; k++) begin
            check($sformatf("u%0d_rdata_a", k), 32'(obs_rda[k]), 32'(exp_rda[k]));
            check($sformatf("u%0d_rvalid_a", k), 32'(rva[k]), 32'(exp_rva[k]));
            check($sformatf("u%0d_rdata_b", k), 32'(obs_rdb[k]), 32'(exp_rdb[k]));
            check($sformatf("u%0d_rvalid_b", k), 32'(rvb[k]), 32'(exp_rvb[k]));
        end
    endtask

    // Drive one edge's worth of inputs, advance the model, then sample 1 ns after the edge.
    task automatic cycle(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                         input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab);
        we = w; waddr = wa; wdata = wd;
        re_a = ea; raddr_a = aa; re_b = eb; raddr_b = ab;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    // Reset pulse placed between edges; outputs must clear with no clock edge.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        compare_all();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with A, reset mid-cycle, then every address reads back 0.
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 3'(i), 8'hAA, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd2);
        reset_pulse();
        check("rst_async_rvalid_a", 32'(rva[0]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i));
            check("rst_readback_u3", 32'(rda3), 32'd0);
        end

        // Basic write then dual read, then hold with re low.
        cycle(1'b1, 3'd3, 8'h05, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b1, 3'd1, 8'h0C, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd1);
        check("basic_rdata_a", 32'(rda0), 32'h5);
        check("basic_rdata_b", 32'(rdb0), 32'hC);
        idle();
        check("basic_hold_a", 32'(rda0), 32'h5);
        check("basic_hold_valid", 32'(rva[0]), 32'd0);

        // Read/write collision on entry 2.
        cycle(1'b1, 3'd2, 8'h01, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b1, 3'd2, 8'h09, 1'b1, 3'd2, 1'b0, 3'd0);
        check("coll_bypass", 32'(rda0), 32'h9);
        check("coll_nobypass", 32'(rda1), 32'h1);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd2);
        check("coll_after_nobypass", 32'(rda1), 32'h9);

        // Zero register: write and collide on entry 0.
        cycle(1'b1, 3'd0, 8'h0F, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0);
        check("zr_read_a", 32'(rda2), 32'h0);
        check("nozr_read_a", 32'(rda0), 32'hF);
        cycle(1'b1, 3'd0, 8'h07, 1'b1, 3'd0, 1'b1, 3'd0);
        check("zr_coll_b", 32'(rdb2), 32'h0);
        check("nozr_coll_b", 32'(rdb0), 32'h7);

        // Address-dependent pattern, read back in reverse on alternating ports.
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 3'(i), 8'(8'h11 * i), 1'b0, 3'd0, 1'b0, 3'd0);
        for (int i = 7; i >= 0; i--) begin
            if (i % 2 == 0) begin
                cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0, 3'd0);
                check("sweep_u3_a", 32'(rda3), 32'(8'h11 * i));
            end else begin
                cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'(i));
                check("sweep_u3_b", 32'(rdb3), 32'(8'h11 * i));
            end
        end

        // Random traffic with occasional mid-operation reset.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom), 3'($urandom), 8'($urandom),
                  1'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) == 0) begin
                we = 1'b1;
                re_a = 1'b1;
                re_b = 1'b1;
                reset_pulse();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
